// File: rtl/hazard_if.sv
// ID-stage hazard bundle: decoded D-stage fields in, stall/flush/forward controls
// and event counters out.
interface hazard_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs_d;
  logic [4:0]       rt_d;
  logic [4:0]       wreg_d;
  logic             regwrite_d;
  logic             memtoreg_d;
  logic             branch_d;
  logic             jr_d;
  logic             pcsrc_d;

  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             flush_e;
  logic             forward_ad;
  logic             forward_bd;
  logic [1:0]       forward_ae;
  logic [1:0]       forward_be;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs_d, rt_d, wreg_d, regwrite_d, memtoreg_d, branch_d, jr_d, pcsrc_d,
    input  stall_f, stall_d, flush_d, flush_e, forward_ad, forward_bd,
           forward_ae, forward_be, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs_d, rt_d, wreg_d, regwrite_d, memtoreg_d, branch_d, jr_d, pcsrc_d,
    output stall_f, stall_d, flush_d, flush_e, forward_ad, forward_bd,
           forward_ae, forward_be, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: tracks E/M/W destinations in a
// shadow pipeline and derives stalls, flushes, forwarding selects and statistics.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  hz
);

  logic [4:0]       rs_e, rt_e, wreg_e;
  logic             regwrite_e, memtoreg_e;
  logic [4:0]       wreg_m;
  logic             regwrite_m, memtoreg_m;
  logic [4:0]       wreg_w;
  logic             regwrite_w;

  logic             e_rs, e_rt, m_rs, m_rt;
  logic             lwstall, brstall, stall, redirect;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // $0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic producer_match(input logic       rw,
                                          input logic [4:0] wreg,
                                          input logic [4:0] src);
    return rw && (wreg == src) && (src != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic       rw_m,
                                         input logic [4:0] wreg_mm,
                                         input logic       rw_w,
                                         input logic [4:0] wreg_ww,
                                         input logic [4:0] src);
    if (producer_match(rw_m, wreg_mm, src))      return 2'b10;
    else if (producer_match(rw_w, wreg_ww, src)) return 2'b01;
    else                                         return 2'b00;
  endfunction

  always_comb begin
    e_rs    = producer_match(regwrite_e, wreg_e, hz.rs_d);
    e_rt    = producer_match(regwrite_e, wreg_e, hz.rt_d);
    m_rs    = producer_match(regwrite_m, wreg_m, hz.rs_d);
    m_rt    = producer_match(regwrite_m, wreg_m, hz.rt_d);
    lwstall = memtoreg_e & (e_rs | e_rt);
    // JR only reads rs; branches compare both operands in ID.
    brstall = (hz.branch_d & (e_rs | e_rt | (memtoreg_m & (m_rs | m_rt))))
            | (hz.jr_d & (e_rs | (memtoreg_m & m_rs)));
    stall    = ~reset & (lwstall | brstall);
    redirect = ~reset & hz.pcsrc_d & ~stall;
    fwd_a    = fwd_sel(regwrite_m, wreg_m, regwrite_w, wreg_w, rs_e);
    fwd_b    = fwd_sel(regwrite_m, wreg_m, regwrite_w, wreg_w, rt_e);
  end

  always_comb begin
    hz.stall_f    = stall;
    hz.stall_d    = stall;
    hz.flush_e    = stall;
    hz.flush_d    = redirect;
    hz.forward_ad = ~reset & m_rs;
    hz.forward_bd = ~reset & m_rt;
    hz.forward_ae = reset ? 2'b00 : fwd_a;
    hz.forward_be = reset ? 2'b00 : fwd_b;
    hz.stall_cnt  = stall_cnt;
    hz.flush_cnt  = flush_cnt;
  end

  // A stall injects a bubble at E while M and W keep draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_e       <= 5'd0;
      rt_e       <= 5'd0;
      wreg_e     <= 5'd0;
      regwrite_e <= 1'b0;
      memtoreg_e <= 1'b0;
      wreg_m     <= 5'd0;
      regwrite_m <= 1'b0;
      memtoreg_m <= 1'b0;
      wreg_w     <= 5'd0;
      regwrite_w <= 1'b0;
    end else begin
      if (stall) begin
        rs_e       <= 5'd0;
        rt_e       <= 5'd0;
        wreg_e     <= 5'd0;
        regwrite_e <= 1'b0;
        memtoreg_e <= 1'b0;
      end else begin
        rs_e       <= hz.rs_d;
        rt_e       <= hz.rt_d;
        wreg_e     <= hz.wreg_d;
        regwrite_e <= hz.regwrite_d;
        memtoreg_e <= hz.memtoreg_d;
      end
      wreg_m     <= wreg_e;
      regwrite_m <= regwrite_e;
      memtoreg_m <= memtoreg_e;
      wreg_w     <= wreg_m;
      regwrite_w <= regwrite_m;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: full-width instance plus a narrow-counter
// instance fed identical stimulus so counter saturation is reachable quickly.
module tb_hazard_ctrl;

  localparam int SMALL_W   = 5;
  localparam int SMALL_MAX = (1 << SMALL_W) - 1;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   exp_stall;
  int   exp_flush;

  hazard_if #(.CNT_W(16))      hz ();
  hazard_if #(.CNT_W(SMALL_W)) hz_s ();

  hazard_ctrl #(.CNT_W(16))      dut   (.clk(clk), .reset(reset), .hz(hz));
  hazard_ctrl #(.CNT_W(SMALL_W)) dut_s (.clk(clk), .reset(reset), .hz(hz_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wreg,
                       input logic rw, input logic mtr, input logic br, input logic jr,
                       input logic pc);
    hz.rs_d = rs;         hz_s.rs_d = rs;
    hz.rt_d = rt;         hz_s.rt_d = rt;
    hz.wreg_d = wreg;     hz_s.wreg_d = wreg;
    hz.regwrite_d = rw;   hz_s.regwrite_d = rw;
    hz.memtoreg_d = mtr;  hz_s.memtoreg_d = mtr;
    hz.branch_d = br;     hz_s.branch_d = br;
    hz.jr_d = jr;         hz_s.jr_d = jr;
    hz.pcsrc_d = pc;      hz_s.pcsrc_d = pc;
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear();
    idle();
    repeat (3) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stall_f/stall_d/flush_e must always agree; flush_d checked alongside
  task automatic chk_hz(input string tag, input logic s, input logic f);
    chk({tag, ".stall"}, {29'd0, hz.stall_f, hz.stall_d, hz.flush_e}, {29'd0, s, s, s});
    chk({tag, ".flush_d"}, {31'd0, hz.flush_d}, {31'd0, f});
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".stall_cnt"}, {16'd0, hz.stall_cnt}, exp_stall);
    chk({tag, ".flush_cnt"}, {16'd0, hz.flush_cnt}, exp_flush);
  endtask

  initial begin
    tests = 0; fails = 0; exp_stall = 0; exp_flush = 0;

    // reset with live-looking D inputs
    reset = 1'b1;
    drive(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_hz("rst", 1'b0, 1'b0);
    chk("rst.fwd_d", {30'd0, hz.forward_ad, hz.forward_bd}, 32'd0);
    chk("rst.fwd_e", {28'd0, hz.forward_ae, hz.forward_be}, 32'd0);
    chk_cnt("rst");
    tick();
    reset = 1'b0;
    idle();
    repeat (3) tick();
    chk_hz("idle", 1'b0, 1'b0);
    chk_cnt("idle");

    // LW $2 then ADD $4,$2,$5: one load-use stall, then W forwarding
    drive(5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_hz("lw.issue", 1'b0, 1'b0);
    tick();
    drive(5'd2, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_hz("lwuse.stall", 1'b1, 1'b0);
    tick(); exp_stall++;
    chk_hz("lwuse.release", 1'b0, 1'b0);
    chk_cnt("lwuse");
    tick();
    idle();
    chk("lwuse.fwd_ae", {30'd0, hz.forward_ae}, 32'd1);
    chk("lwuse.fwd_be", {30'd0, hz.forward_be}, 32'd0);

    // ADD $3,$1,$1 then SUB $6,$3,$3: both operands from M, no stall
    clear();
    drive(5'd1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd3, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_hz("alu2alu", 1'b0, 1'b0);
    tick();
    idle();
    chk("alu2alu.fwd_ae", {30'd0, hz.forward_ae}, 32'd2);
    chk("alu2alu.fwd_be", {30'd0, hz.forward_be}, 32'd2);

    // $3 written by both M and W: M must win
    clear();
    drive(5'd1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd3, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("mprio.fwd_ae", {30'd0, hz.forward_ae}, 32'd2);
    chk("mprio.fwd_be", {30'd0, hz.forward_be}, 32'd0);

    // W-only producer on operand B
    clear();
    drive(5'd1, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    drive(5'd4, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("wfwd.fwd_ae", {30'd0, hz.forward_ae}, 32'd0);
    chk("wfwd.fwd_be", {30'd0, hz.forward_be}, 32'd1);

    // ADD $7 in E, BEQ $7,$0 with redirect: stall suppresses flush, then ID forward
    clear();
    drive(5'd1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_hz("beq.stall", 1'b1, 1'b0);
    tick(); exp_stall++;
    chk_hz("beq.resolve", 1'b0, 1'b1);
    chk("beq.fwd_ad", {31'd0, hz.forward_ad}, 32'd1);
    chk("beq.fwd_bd", {31'd0, hz.forward_bd}, 32'd0);
    tick(); exp_flush++;
    idle();
    chk_cnt("beq");

    // JR $31 after ADDI $31 (rt_d aliases $31 too)
    clear();
    drive(5'd1, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_hz("jr.stall", 1'b1, 1'b0);
    tick(); exp_stall++;
    chk_hz("jr.resolve", 1'b0, 1'b1);
    chk("jr.fwd_ad", {31'd0, hz.forward_ad}, 32'd1);
    chk("jr.fwd_bd", {31'd0, hz.forward_bd}, 32'd1);
    tick(); exp_flush++;

    // JR must ignore a match on rt
    clear();
    drive(5'd1, 5'd12, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd5, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_hz("jr.rt_ignored", 1'b0, 1'b1);
    tick(); exp_flush++;

    // ADDI $0 in E, BEQ $0,$0: register 0 never matches
    clear();
    drive(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_hz("zero.nostall", 1'b0, 1'b1);
    tick(); exp_flush++;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("zero.fwd_d", {30'd0, hz.forward_ad, hz.forward_bd}, 32'd0);
    chk_cnt("zero");

    // LW $2, unrelated ADD, then BEQ $2,$3: stall from the M-stage load
    clear();
    drive(5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd1, 5'd1, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_hz("lwbr.stall", 1'b1, 1'b0);
    chk("lwbr.fwd_ad", {31'd0, hz.forward_ad}, 32'd1);
    tick(); exp_stall++;
    chk_hz("lwbr.release", 1'b0, 1'b0);
    chk("lwbr.fwd_ad2", {31'd0, hz.forward_ad}, 32'd0);

    // load-use through rt
    clear();
    drive(5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd5, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_hz("lwrt.stall", 1'b1, 1'b0);
    tick(); exp_stall++;
    clear();
    chk_cnt("pre_sat");

    // two stall cycles per three clocks, enough to saturate the narrow counters
    for (int i = 0; i < 18; i++) begin
      drive(5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_hz("sat.lw", 1'b0, 1'b0);
      tick();
      drive(5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_hz("sat.stall_e", 1'b1, 1'b0);
      tick(); exp_stall++;
      chk_hz("sat.stall_m", 1'b1, 1'b0);
      tick(); exp_stall++;
    end
    idle();
    chk_cnt("sat.wide");
    chk("sat.small_stall", {27'd0, hz_s.stall_cnt},
        (exp_stall > SMALL_MAX) ? SMALL_MAX : exp_stall);
    chk("sat.small_flush", {27'd0, hz_s.flush_cnt}, exp_flush);
    tick();
    chk("sat.small_hold", {27'd0, hz_s.stall_cnt}, SMALL_MAX);

    // reset coinciding with a pending load-use stall clears everything
    clear();
    drive(5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd2, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    chk_hz("rst2.gated", 1'b0, 1'b0);
    tick();
    exp_stall = 0; exp_flush = 0;
    chk_cnt("rst2");
    chk("rst2.small_stall", {27'd0, hz_s.stall_cnt}, 32'd0);
    reset = 1'b0;
    idle();
    tick();
    chk_cnt("rst2.after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard controller for the 5-stage pipelined MIPS core. It keeps its own shadow copy of the destination-register state for the E, M and W stages. From that state and the instruction currently in ID it drives:
- stall and flush of the IF/ID/EX pipeline registers
- the ID-stage equality-compare forwarding selects
- the EX-stage ALU-operand forwarding selects
It also keeps saturating stall and flush event counters for end-of-run statistics.

Parameters:
CNT_W, 16, width of the stall and flush event counters

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock, one synchronous active-high reset
rs_d  input  5  ID-stage source register A1 (cmd[25:21])
rt_d  input  5  ID-stage source register A2 (cmd[20:16])
wreg_d  input  5  ID-stage resolved destination: rd for R-type, rt for ADDI/LW, 31 for JAL
regwrite_d  input  1  ID instruction writes the register file
memtoreg_d  input  1  ID instruction is LW
branch_d  input  1  ID instruction is BEQ or BNE (compares rs and rt)
jr_d  input  1  ID instruction is JR (reads rs only)
pcsrc_d  input  1  ID-stage redirect request (taken branch, JAL, JR)
stall_f  output  1  hold PC
stall_d  output  1  hold IF/ID register
flush_d  output  1  clear IF/ID register
flush_e  output  1  load bubble into ID/EX register (the ID stage's FlushE)
forward_ad  output  1  ID comparator operand A takes ALUOutM
forward_bd  output  1  ID comparator operand B takes ALUOutM
forward_ae  output  2  EX operand A: 00 RD1E, 01 ResultW, 10 ALUOutM
forward_be  output  2  EX operand B: same encoding
stall_cnt  output  CNT_W  cycles with stall asserted
flush_cnt  output  CNT_W  cycles with flush_d asserted

Behaviour:
Shadow pipeline state (registered):
- E stage: rs_e, rt_e, wreg_e, regwrite_e, memtoreg_e.
- M stage: wreg_m, regwrite_m, memtoreg_m.
- W stage: wreg_w, regwrite_w.
- On each rising edge:
  - E loads the D-stage inputs, or all zeros if flush_e = 1.
  - M loads E; W loads M.
- On reset: all shadow fields, stall_cnt and flush_cnt go to 0.

Matching rules:
- A producer matches a source register only if its regwrite = 1, its wreg = that source, and the source is non-zero.
- Register $0 never matches.

Hazard outputs are combinational from the shadow state and the D inputs, with zero latency:
- lwstall = memtoreg_e and the E producer matches rs_d or rt_d.
- brstall applies when branch_d or jr_d is set. It is 1 if either:
  - the E producer matches rs_d (or rt_d, for branch_d only), or
  - memtoreg_m = 1 and the M producer matches the same operands.
- jr_d never checks rt_d.
- stall = lwstall | brstall.
- stall_f = stall_d = stall.
- flush_e = stall.
- flush_d = pcsrc_d & ~stall. A redirect raised during a stall is ignored because its operands are invalid; the redirect re-evaluates next cycle.
- forward_ad = M producer matches rs_d; forward_bd = M producer matches rt_d.
- forward_ae = 10 if the M producer matches rs_e, else 01 if the W producer matches rs_e, else 00. M priority over W is mandatory.
- forward_be: same rule using rt_e.

Counters:
- stall_cnt increments on each clock with stall = 1; flush_cnt increments on each clock with flush_d = 1.
- Both saturate at all-ones; no wrap.
- Reset asserted in the same cycle as an event wins: the counter goes to 0.

Reset outputs: with all shadow state zero, every output is 0, whatever the D inputs.

Stalling does not freeze E/M/W: the bubble is inserted at E and older instructions drain.

Test Plan:
- reset=1 with rs_d=3, pcsrc_d=1 -> all outputs 0. After release with idle inputs, both counters stay 0.
- LW $2 in D, then ADD $4,$2,$5 in D -> ADD cycle: stall_f=stall_d=flush_e=1 for exactly one cycle. Next cycle forward_ae=01. stall_cnt=1.
- ADD $3,$1,$1 then SUB $6,$3,$3 back-to-back -> SUB in E: forward_ae=10 and forward_be=10, no stall.
- Same destination written by both M and W (ADD $3, ADD $3, then use of $3) -> forward_ae=10, not 01.
- ADD $7 in E, BEQ $7,$0 in D, pcsrc_d=1 -> stall=1, flush_d=0. Next cycle: stall=0, forward_ad=1, flush_d=1, flush_cnt=1.
- JR $31 in D with ADDI writing $31 in E and rt_d=$31 alias -> one stall cycle. ADDI writing $0 in E with BEQ $0,$0 -> no stall.
- Force 2^CNT_W+3 stall cycles -> stall_cnt holds 0xFFFF. Then reset -> 0.
